seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised, multi-cycle, non-restoring integer divider; successor to the fixed 32-bit start/finished divider. Adds WIDTH parametrisation, per-operation signed/unsigned mode, divide-by-zero and signed-overflow handling, and valid/ready handshakes on both sides. It is the divide unit behind the ALU's DIV/REM operations: one quotient bit per cycle, results held until the consumer accepts them.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4).
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns to IDLE, drops any operation or result.
- in_valid  input  1  operation offered.
- in_ready  output  1  high only in IDLE; an operation is accepted on in_valid && in_ready.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- dividend  input  WIDTH  numerator; sampled at accept.
- divisor  input  WIDTH  denominator; sampled at accept.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts the result on out_valid && out_ready.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  the held result came from divisor == 0.
- overflow  output  1  the held result came from signed MIN / -1.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE → ITER on accept: latch |dividend| into the quotient shift register, |divisor| into the (WIDTH+1)-bit divisor register, clear the (WIDTH+1)-bit partial remainder, set count=0, and record sign_q = sd^sv and sign_r = sd. Magnitudes are taken only when is_signed; unsigned operands pass through unchanged.
- IDLE → DONE on accept when divisor == 0. Set quotient = all ones, remainder = dividend, div_by_zero=1. No iteration is performed.
- ITER, one step per cycle:
  - Shift {R,Q} left by 1.
  - If R ≥ 0, R = R − D; otherwise R = R + D.
  - Q[0] = ~R[WIDTH].
  - count++. Go to FIX when count reaches WIDTH−1 at this edge, i.e. after WIDTH steps.
- FIX, one cycle:
  - If R < 0, add D to R.
  - Negate Q if sign_q; negate R if sign_r.
  - Truncate both to WIDTH bits. Go to DONE.
- Signed semantics: quotient truncates toward zero; the remainder takes the dividend's sign.
- Signed MIN / −1 needs no special path: the magnitude path yields quotient = MIN, remainder = 0. Set overflow=1 when this case is detected at accept.
- DONE: outputs are stable while out_valid=1. Go to IDLE on out_valid && out_ready.
- flush has priority over every transition. reset_n low has priority over flush.

## Timing
- Reset values:
  - in_ready=1 after reset, since state is IDLE.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - count=0, state=IDLE.
- Normal latency: the accept edge enters ITER. out_valid rises at the (WIDTH+1)th rising edge after the accept edge, which is 33 for WIDTH=32.
- Divide-by-zero latency: out_valid rises at the accept edge itself.
- in_ready drops at the accept edge. It returns to 1 on the edge after the result handshake. The design does not accept a new operation in the same cycle as the result handshake.
- out_ready held low keeps DONE indefinitely; outputs must not change.
- flush asserted in any state: next edge gives IDLE, out_valid=0, flags cleared. If flush and in_valid coincide in IDLE, the operation is not accepted.
- reset_n asserted mid-ITER: all state returns to reset values immediately, without waiting for a clock edge.
- Inputs are don't-care outside the accept cycle.

## Structure
- Package divider_pkg holds:
  - the state enum (IDLE/ITER/FIX/DONE);
  - the localparam for the count width, $clog2(WIDTH);
  - a function giving the divide-by-zero quotient (all ones).
- Sub-module div_step: a combinational single non-restoring iteration, parametrised by WIDTH. Inputs are R, Q and D; outputs are the next R and next Q. It can be reused for a future unrolled or radix-4 variant.

## Test plan
All cases use WIDTH=32.
- Unsigned 100 / 7: in_ready returns 0, out_valid is seen 33 edges after accept, q=14, r=2, both flags 0.
- Signed −7 / 2: q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Signed 7 / −2: q=−3, r=1.
- Unsigned 0x1234 / 0: out_valid at the accept edge, q=0xFFFFFFFF, r=0x1234, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0, overflow=1. The same operands unsigned give q=0, r=0x80000000, overflow=0.
- Unsigned 0xFFFFFFFF / 1 with out_ready held low for 10 cycles: outputs stay at q=0xFFFFFFFF, r=0 throughout; in_ready=1 one edge after out_ready is raised.
- Aborts:
  - reset_n pulsed low at ITER count=10: outputs are zero at once and in_ready=1.
  - flush at count=20: IDLE on the next edge. A following 9 / 3 then gives q=3, r=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential divider: FSM states, counter
// sizing and the divide-by-zero quotient pattern.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      DONE
   } state_t;

   localparam int MAX_WIDTH = 64;
   localparam int DIV_WIDTH = 32;
   localparam int CNT_WIDTH = $clog2(DIV_WIDTH);

   function automatic int count_width(input int width);
      return $clog2(width);
   endfunction

   // All ones; callers size-cast down to their operand width.
   function automatic logic [MAX_WIDTH-1:0] dbz_quotient();
      return '1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step: shift {R,Q} left, then
// subtract or add D depending on the sign of the incoming partial remainder.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH:0]   d,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] r_shift;

   // Add/sub wrap modulo 2^(WIDTH+1); the true result always fits, so the
   // wrapped intermediate of the shift is harmless.
   always_comb begin
      r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
      r_next  = r[WIDTH] ? (r_shift + d) : (r_shift - d);
      q_next  = {q[WIDTH-2:0], ~r_next[WIDTH]};
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned non-restoring divider, one quotient bit per
// cycle, with valid/ready on both sides and divide-by-zero/overflow flags.
module seq_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int               CW    = count_width(WIDTH);
   localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(dbz_quotient());
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, state_next;
   logic [WIDTH:0]   r_q, d_q, r_step;
   logic [WIDTH-1:0] q_q, q_step;
   logic [CW-1:0]    count;
   logic             sign_q, sign_r;
   logic             accept;

   logic             sd, sv, is_zero, is_ovf;
   logic [WIDTH-1:0] abs_dd, abs_dv, r_low, q_fix, r_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_q),
      .q      (q_q),
      .d      (d_q),
      .r_next (r_step),
      .q_next (q_step)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      in_ready   = (state == IDLE);
      out_valid  = (state == DONE);
      accept     = in_valid && in_ready && !flush;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (accept) state_next = is_zero ? DONE : ITER;
            ITER: if (count == LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      sd      = is_signed & dividend[WIDTH-1];
      sv      = is_signed & divisor[WIDTH-1];
      is_zero = (divisor == '0);
      is_ovf  = is_signed && (dividend == MIN_V) && (&divisor);
      abs_dd  = sd ? -dividend : dividend;
      abs_dv  = sv ? -divisor  : divisor;
      // Final correction of a negative remainder; D's top bit is always zero.
      r_low   = r_q[WIDTH-1:0] + (r_q[WIDTH] ? d_q[WIDTH-1:0] : '0);
      q_fix   = sign_q ? -q_q   : q_q;
      r_fix   = sign_r ? -r_low : r_low;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         count       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (flush) begin
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_zero) begin
                     quotient    <= DBZ_Q;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                  end else begin
                     r_q         <= '0;
                     q_q         <= abs_dd;
                     d_q         <= {1'b0, abs_dv};
                     count       <= '0;
                     sign_q      <= sd ^ sv;
                     sign_r      <= sd;
                     div_by_zero <= 1'b0;
                     overflow    <= is_ovf;
                  end
               end
            end
            ITER: begin
               r_q   <= r_step;
               q_q   <= q_step;
               count <= (count == LAST) ? '0 : count + CW'(1);
            end
            FIX: begin
               quotient  <= q_fix;
               remainder <= r_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32): stimulus pushes expected results
// into a scoreboard queue; a monitor pops and compares on each result handshake.
module tb_seq_divider;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset_n, flush, in_valid, in_ready, is_signed;
   logic         out_valid, out_ready, div_by_zero, overflow;
   logic [W-1:0] dividend, divisor, quotient, remainder;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits for in_ready, offers one operation, returns #1 after the accept edge.
   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input logic eovf);
      int n = 0;
      exp_t e;
      while (!in_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_wait: in_ready still 0 after %0d cycles, required 1", n);
      end
      is_signed = s;
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      @(posedge clock);
      if (push) begin
         e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
         sb.push_back(e);
      end
      #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: q=0x%0h r=0x%0h with empty scoreboard", quotient, remainder);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient",    quotient,       e.q);
            check("remainder",   remainder,      e.r);
            check("div_by_zero", W'(div_by_zero), W'(e.dbz));
            check("overflow",    W'(overflow),    W'(e.ovf));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      int n;
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #1;
      check("rst_in_ready",  W'(in_ready),    W'(1'b1));
      check("rst_out_valid", W'(out_valid),   W'(1'b0));
      check("rst_quotient",  quotient,        '0);
      check("rst_remainder", remainder,       '0);
      check("rst_dbz",       W'(div_by_zero), W'(1'b0));
      check("rst_ovf",       W'(overflow),    W'(1'b0));
      #11 reset_n = 1'b1;
      @(posedge clock); #1;

      // Unsigned 100 / 7 with latency measurement
      issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);
      check("accept_in_ready", W'(in_ready), W'(1'b0));
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!out_valid && lat < 40);
      check("latency", W'(lat), W'(33));

      // Signed sign rules
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);

      // Divide by zero completes at the accept edge
      issue(1'b0, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
      check("dbz_latency", W'(out_valid), W'(1'b1));

      // MIN / -1, signed then unsigned
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

      // Back-pressure: result held while out_ready is low
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         check("stall_valid", W'(out_valid), W'(1'b1));
         check("stall_q",     quotient,      32'hFFFF_FFFF);
         check("stall_r",     remainder,     32'd0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("stall_release_in_ready", W'(in_ready), W'(1'b1));

      // Asynchronous reset mid-iteration at count=10
      issue(1'b0, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0, 1'b0);
      repeat (10) @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("arst_in_ready",  W'(in_ready),  W'(1'b1));
      check("arst_out_valid", W'(out_valid), W'(1'b0));
      check("arst_quotient",  quotient,      '0);
      check("arst_remainder", remainder,     '0);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;

      // Flush at count=20
      issue(1'b0, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0, 1'b0);
      repeat (20) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("flush_in_ready",  W'(in_ready),  W'(1'b1));
      check("flush_out_valid", W'(out_valid), W'(1'b0));

      // Flush coinciding with in_valid in IDLE blocks the accept
      flush     = 1'b1;
      in_valid  = 1'b1;
      is_signed = 1'b0;
      dividend  = 32'd5;
      divisor   = 32'd0;
      @(posedge clock); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_accept_in_ready",  W'(in_ready),  W'(1'b1));
      check("flush_accept_out_valid", W'(out_valid), W'(1'b0));

      issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check("sb_drained", W'(sb.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
